// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the 5-stage pipeline forwarding / hazard logic.
//   FWD_*      : encodings of the per-port forwarding select
//   mc_slot_t  : one in-flight multi-cycle write (valid, destination, countdown)
// The slot record is sized for the widest address/latency any pipeline
// configuration uses; narrower configurations keep the upper bits at zero.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam logic [1:0] FWD_ORIG = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;

    localparam int MC_ADDR_W_MAX = 8;
    localparam int MC_LAT_W_MAX  = 8;

    typedef struct packed {
        logic                     valid;
        logic [MC_ADDR_W_MAX-1:0] addr;
        logic [MC_LAT_W_MAX-1:0]  cnt;
    } mc_slot_t;

endpackage

// File: rtl/mc_slot.sv
// ---------------------------------------------------------------------------
// mc_slot
// One scoreboard entry for an outstanding multi-cycle register write.
//   clk, rst          : clock, synchronous active-high reset (entry invalid)
//   load_i            : allocate: valid=1, addr=load_addr_i, cnt=load_cnt_i
//   clear_i           : retire: entry becomes invalid
//   valid_o, addr_o   : entry state
//   cnt_zero_o        : countdown has reached zero
// A valid entry counts down by one per cycle and then holds at zero until
// it is cleared.
// ---------------------------------------------------------------------------
module mc_slot
    import pipe_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [LAT_W-1:0]  load_cnt_i,
    input  logic              clear_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              cnt_zero_o
);

    mc_slot_t slot_q;
    mc_slot_t slot_d;

    always_comb begin
        slot_d = slot_q;
        if (clear_i) begin
            slot_d = '0;
        end else if (load_i) begin
            slot_d.valid = 1'b1;
            slot_d.addr  = MC_ADDR_W_MAX'(load_addr_i);
            slot_d.cnt   = MC_LAT_W_MAX'(load_cnt_i);
        end else if (slot_q.valid && (slot_q.cnt != '0)) begin
            slot_d.cnt = slot_q.cnt - MC_LAT_W_MAX'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid_o    = slot_q.valid;
    assign addr_o     = ADDR_W'(slot_q.addr);
    assign cnt_zero_o = (slot_q.cnt == '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// ---------------------------------------------------------------------------
// fwd_hazard_unit
// Forwarding selects, load-use stall and multi-cycle write scoreboard.
//   clk, rst                  : clock, synchronous active-high reset
//   rf_raddr_ID/rf_rused_ID   : ID read ports and "operand used" flags
//   rf_wen_ID/rf_waddr_ID     : ID destination, mc_req_ID: ID op is multi-cycle
//   rf_raddr_EX               : EX read ports (forwarding targets)
//   rf_wen_EX/rf_waddr_EX     : EX destination, mem_read_EX: EX op is a load
//   mc_issue_EX/mc_lat_EX     : multi-cycle op leaving EX and its latency
//   rf_wen_MEM/WB, addr       : later-stage writers (forwarding sources)
//   sel_rf                    : per-port select 00 orig / 01 MEM / 10 WB
//   stall_ID                  : hold front end, bubble into EX
//   mc_retire/mc_retire_addr  : multi-cycle result writes the RF this cycle
//   mc_err                    : sticky, an issue found no free slot
// ---------------------------------------------------------------------------
module fwd_hazard_unit
    import pipe_pkg::*;
#(
    parameter int NUM_RD   = 2,
    parameter int ADDR_W   = 5,
    parameter int MC_SLOTS = 2,
    parameter int LAT_W    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rf_raddr_ID,
    input  logic [NUM_RD-1:0]        rf_rused_ID,
    input  logic                     rf_wen_ID,
    input  logic [ADDR_W-1:0]        rf_waddr_ID,
    input  logic                     mc_req_ID,
    input  logic [NUM_RD*ADDR_W-1:0] rf_raddr_EX,
    input  logic                     rf_wen_EX,
    input  logic [ADDR_W-1:0]        rf_waddr_EX,
    input  logic                     mem_read_EX,
    input  logic                     mc_issue_EX,
    input  logic [LAT_W-1:0]         mc_lat_EX,
    input  logic                     rf_wen_MEM,
    input  logic [ADDR_W-1:0]        rf_waddr_MEM,
    input  logic                     rf_wen_WB,
    input  logic [ADDR_W-1:0]        rf_waddr_WB,
    output logic [NUM_RD*2-1:0]      sel_rf,
    output logic                     stall_ID,
    output logic                     mc_retire,
    output logic [ADDR_W-1:0]        mc_retire_addr,
    output logic                     mc_err
);

    localparam int CNT_W = $clog2(MC_SLOTS + 1);

    logic [MC_SLOTS-1:0] slot_valid;
    logic [MC_SLOTS-1:0] slot_zero;
    logic [MC_SLOTS-1:0] slot_load;
    logic [MC_SLOTS-1:0] slot_clear;
    logic [ADDR_W-1:0]   slot_addr [MC_SLOTS];
    logic [LAT_W-1:0]    load_cnt;
    logic                alloc_found;
    logic                retire_found;
    logic [CNT_W-1:0]    free_cnt;
    logic [NUM_RD-1:0]   port_lu;
    logic [NUM_RD-1:0]   port_raw;
    logic                haz_waw;
    logic                haz_struct;
    logic                haz_load_use;
    logic                mc_err_q;
    logic                mc_err_d;

    // A zero latency would retire with no countdown; treat it as one cycle.
    assign load_cnt = (mc_lat_EX == '0) ? LAT_W'(1) : mc_lat_EX;

    genvar gi;
    generate
        for (gi = 0; gi < MC_SLOTS; gi++) begin : g_slot
            mc_slot #(
                .ADDR_W (ADDR_W),
                .LAT_W  (LAT_W)
            ) u_slot (
                .clk         (clk),
                .rst         (rst),
                .load_i      (slot_load[gi]),
                .load_addr_i (rf_waddr_EX),
                .load_cnt_i  (load_cnt),
                .clear_i     (slot_clear[gi]),
                .valid_o     (slot_valid[gi]),
                .addr_o      (slot_addr[gi]),
                .cnt_zero_o  (slot_zero[gi])
            );
        end
    endgenerate

    // Allocation looks only at slots free at the start of the cycle, so a
    // slot retiring now is never handed out in the same cycle.
    always_comb begin
        slot_load   = '0;
        alloc_found = 1'b0;
        free_cnt    = '0;
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (!slot_valid[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!alloc_found) begin
                    slot_load[i] = mc_issue_EX;
                    alloc_found  = 1'b1;
                end
            end
        end
    end

    // Lowest-index finished slot retires; others wait at zero.
    always_comb begin
        slot_clear     = '0;
        retire_found   = 1'b0;
        mc_retire_addr = '0;
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (slot_valid[i] && slot_zero[i] && !retire_found) begin
                slot_clear[i]  = 1'b1;
                retire_found   = 1'b1;
                mc_retire_addr = slot_addr[i];
            end
        end
    end
    assign mc_retire = retire_found;

    generate
        for (gi = 0; gi < NUM_RD; gi++) begin : g_port
            logic [ADDR_W-1:0] ex_addr;
            logic [ADDR_W-1:0] id_addr;
            logic              mc_hit;

            assign ex_addr = rf_raddr_EX[gi*ADDR_W +: ADDR_W];
            assign id_addr = rf_raddr_ID[gi*ADDR_W +: ADDR_W];

            // $zero is hardwired, so it is never forwarded.
            assign sel_rf[gi*2 +: 2] =
                (ex_addr == '0)                            ? FWD_ORIG :
                (rf_wen_MEM && (ex_addr == rf_waddr_MEM))  ? FWD_MEM  :
                (rf_wen_WB  && (ex_addr == rf_waddr_WB))   ? FWD_WB   :
                                                             FWD_ORIG;

            assign port_lu[gi] = rf_rused_ID[gi] && (id_addr == rf_waddr_EX);

            always_comb begin
                mc_hit = 1'b0;
                for (int j = 0; j < MC_SLOTS; j++) begin
                    if (slot_valid[j] && (slot_addr[j] != '0) && (slot_addr[j] == id_addr)) begin
                        mc_hit = 1'b1;
                    end
                end
            end
            assign port_raw[gi] = rf_rused_ID[gi] && mc_hit;
        end
    endgenerate

    always_comb begin
        haz_waw = 1'b0;
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (rf_wen_ID && slot_valid[i] && (slot_addr[i] == rf_waddr_ID)) begin
                haz_waw = 1'b1;
            end
        end
    end

    assign haz_load_use = mem_read_EX && rf_wen_EX && (rf_waddr_EX != '0) && (|port_lu);
    // An issue leaving EX this cycle consumes one of the currently free slots.
    assign haz_struct   = mc_req_ID && (free_cnt <= CNT_W'(mc_issue_EX));
    assign stall_ID     = haz_load_use || (|port_raw) || haz_waw || haz_struct;

    assign mc_err_d = mc_err_q || (mc_issue_EX && !alloc_found);

    always_ff @(posedge clk) begin
        if (rst) begin
            mc_err_q <= 1'b0;
        end else begin
            mc_err_q <= mc_err_d;
        end
    end
    assign mc_err = mc_err_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    localparam int NUM_RD   = 2;
    localparam int ADDR_W   = 5;
    localparam int MC_SLOTS = 2;
    localparam int LAT_W    = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic [NUM_RD*ADDR_W-1:0] rf_raddr_ID;
    logic [NUM_RD-1:0]        rf_rused_ID;
    logic                     rf_wen_ID;
    logic [ADDR_W-1:0]        rf_waddr_ID;
    logic                     mc_req_ID;
    logic [NUM_RD*ADDR_W-1:0] rf_raddr_EX;
    logic                     rf_wen_EX;
    logic [ADDR_W-1:0]        rf_waddr_EX;
    logic                     mem_read_EX;
    logic                     mc_issue_EX;
    logic [LAT_W-1:0]         mc_lat_EX;
    logic                     rf_wen_MEM;
    logic [ADDR_W-1:0]        rf_waddr_MEM;
    logic                     rf_wen_WB;
    logic [ADDR_W-1:0]        rf_waddr_WB;
    logic [NUM_RD*2-1:0]      sel_rf;
    logic                     stall_ID;
    logic                     mc_retire;
    logic [ADDR_W-1:0]        mc_retire_addr;
    logic                     mc_err;

    fwd_hazard_unit #(
        .NUM_RD   (NUM_RD),
        .ADDR_W   (ADDR_W),
        .MC_SLOTS (MC_SLOTS),
        .LAT_W    (LAT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rf_raddr_ID    (rf_raddr_ID),
        .rf_rused_ID    (rf_rused_ID),
        .rf_wen_ID      (rf_wen_ID),
        .rf_waddr_ID    (rf_waddr_ID),
        .mc_req_ID      (mc_req_ID),
        .rf_raddr_EX    (rf_raddr_EX),
        .rf_wen_EX      (rf_wen_EX),
        .rf_waddr_EX    (rf_waddr_EX),
        .mem_read_EX    (mem_read_EX),
        .mc_issue_EX    (mc_issue_EX),
        .mc_lat_EX      (mc_lat_EX),
        .rf_wen_MEM     (rf_wen_MEM),
        .rf_waddr_MEM   (rf_waddr_MEM),
        .rf_wen_WB      (rf_wen_WB),
        .rf_waddr_WB    (rf_waddr_WB),
        .sel_rf         (sel_rf),
        .stall_ID       (stall_ID),
        .mc_retire      (mc_retire),
        .mc_retire_addr (mc_retire_addr),
        .mc_err         (mc_err)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference state: list of in-flight writes with remaining cycles.
    int m_valid [MC_SLOTS];
    int m_addr  [MC_SLOTS];
    int m_rem   [MC_SLOTS];
    int m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int field(input logic [NUM_RD*ADDR_W-1:0] v, input int k);
        return int'(v[k*ADDR_W +: ADDR_W]);
    endfunction

    function automatic logic [NUM_RD*2-1:0] exp_sel();
        logic [NUM_RD*2-1:0] e;
        int a;
        e = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            a = field(rf_raddr_EX, k);
            if (a != 0 && rf_wen_MEM && a == int'(rf_waddr_MEM))     e[k*2 +: 2] = 2'b01;
            else if (a != 0 && rf_wen_WB && a == int'(rf_waddr_WB))  e[k*2 +: 2] = 2'b10;
        end
        return e;
    endfunction

    function automatic logic exp_stall();
        logic s;
        int   free;
        int   ida;
        s = 1'b0;
        free = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            ida = field(rf_raddr_ID, k);
            if (rf_rused_ID[k]) begin
                if (mem_read_EX && rf_wen_EX && int'(rf_waddr_EX) != 0 && ida == int'(rf_waddr_EX)) s = 1'b1;
                for (int i = 0; i < MC_SLOTS; i++)
                    if (m_valid[i] != 0 && m_addr[i] != 0 && m_addr[i] == ida) s = 1'b1;
            end
        end
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (m_valid[i] != 0) begin
                if (rf_wen_ID && m_addr[i] == int'(rf_waddr_ID)) s = 1'b1;
            end else begin
                free++;
            end
        end
        if (mc_req_ID && (free - (mc_issue_EX ? 1 : 0)) <= 0) s = 1'b1;
        return s;
    endfunction

    function automatic int exp_ret_idx();
        for (int i = 0; i < MC_SLOTS; i++)
            if (m_valid[i] != 0 && m_rem[i] == 0) return i;
        return -1;
    endfunction

    task automatic model_update();
        int r;
        int f;
        if (rst) begin
            for (int i = 0; i < MC_SLOTS; i++) begin
                m_valid[i] = 0; m_addr[i] = 0; m_rem[i] = 0;
            end
            m_err = 0;
            return;
        end
        r = exp_ret_idx();
        f = -1;
        for (int i = 0; i < MC_SLOTS; i++)
            if (m_valid[i] == 0 && f < 0) f = i;
        for (int i = 0; i < MC_SLOTS; i++) begin
            if (m_valid[i] != 0) begin
                if (i == r)            m_valid[i] = 0;
                else if (m_rem[i] > 0) m_rem[i]--;
            end
        end
        if (mc_issue_EX) begin
            if (f >= 0) begin
                m_valid[f] = 1;
                m_addr[f]  = int'(rf_waddr_EX);
                m_rem[f]   = (mc_lat_EX == '0) ? 1 : int'(mc_lat_EX);
            end else begin
                m_err = 1;
            end
        end
    endtask

    // Compare all outputs with the reference, 1 time unit after the inputs settle.
    task automatic model_check();
        int r;
        #1;
        r = exp_ret_idx();
        chk("sel_rf", 32'(sel_rf), 32'(exp_sel()));
        chk("stall_ID", 32'(stall_ID), 32'(exp_stall()));
        chk("mc_retire", 32'(mc_retire), (r >= 0) ? 32'd1 : 32'd0);
        chk("mc_retire_addr", 32'(mc_retire_addr), (r >= 0) ? 32'(m_addr[r]) : 32'd0);
        chk("mc_err", 32'(mc_err), 32'(m_err));
        $display("cyc %0d rst=%b sel=%h stall=%b retire=%b/%0d err=%b",
                 cyc, rst, sel_rf, stall_ID, mc_retire, mc_retire_addr, mc_err);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        rf_raddr_ID = '0; rf_rused_ID = '0; rf_wen_ID = 1'b0; rf_waddr_ID = '0;
        mc_req_ID = 1'b0; rf_raddr_EX = '0; rf_wen_EX = 1'b0; rf_waddr_EX = '0;
        mem_read_EX = 1'b0; mc_issue_EX = 1'b0; mc_lat_EX = '0;
        rf_wen_MEM = 1'b0; rf_waddr_MEM = '0; rf_wen_WB = 1'b0; rf_waddr_WB = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_check();
        step();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MC_SLOTS; i++) begin
            m_valid[i] = 0; m_addr[i] = 0; m_rem[i] = 0;
        end
        m_err = 0;
        idle();
        rst = 1'b1;
        @(negedge clk);
        step();

        // Reset state with all-zero inputs
        model_check();
        chk("rst_sel", 32'(sel_rf), 32'd0);
        chk("rst_stall", 32'(stall_ID), 32'd0);
        chk("rst_retire", 32'(mc_retire), 32'd0);
        chk("rst_err", 32'(mc_err), 32'd0);
        step();
        rst = 1'b0;

        // Forwarding priority
        rf_raddr_EX = {5'd0, 5'd5};
        rf_wen_MEM = 1'b1; rf_waddr_MEM = 5'd5;
        rf_wen_WB  = 1'b1; rf_waddr_WB  = 5'd5;
        model_check();
        chk("fwd_mem", 32'(sel_rf), 32'h1);
        rf_wen_MEM = 1'b0;
        model_check();
        chk("fwd_wb", 32'(sel_rf), 32'h2);
        rf_waddr_WB = 5'd0;
        model_check();
        chk("fwd_zero", 32'(sel_rf), 32'h0);
        step();

        // Load-use
        idle();
        mem_read_EX = 1'b1; rf_wen_EX = 1'b1; rf_waddr_EX = 5'd8;
        rf_raddr_ID = {5'd8, 5'd3}; rf_rused_ID = 2'b10;
        model_check();
        chk("lu_used", 32'(stall_ID), 32'd1);
        rf_rused_ID = 2'b01;
        model_check();
        chk("lu_unused", 32'(stall_ID), 32'd0);
        rf_waddr_EX = 5'd0; rf_raddr_ID = {5'd0, 5'd3}; rf_rused_ID = 2'b10;
        model_check();
        chk("lu_zero", 32'(stall_ID), 32'd0);
        step();

        // Multi-cycle RAW: issue $9 lat 3 in cycle 0
        do_reset();
        mc_issue_EX = 1'b1; rf_waddr_EX = 5'd9; mc_lat_EX = 4'd3;
        model_check();
        step();
        idle();
        rf_raddr_ID = {5'd0, 5'd9}; rf_rused_ID = 2'b01;
        for (int c = 1; c <= 5; c++) begin
            model_check();
            chk("mc_stall", 32'(stall_ID), (c <= 4) ? 32'd1 : 32'd0);
            chk("mc_ret", 32'(mc_retire), (c == 4) ? 32'd1 : 32'd0);
            if (c == 4) chk("mc_ret_addr", 32'(mc_retire_addr), 32'd9);
            step();
        end

        // Retire contention
        do_reset();
        mc_issue_EX = 1'b1; rf_waddr_EX = 5'd10; mc_lat_EX = 4'd2;
        model_check();
        step();
        rf_waddr_EX = 5'd11; mc_lat_EX = 4'd1;
        model_check();
        step();
        idle();
        for (int c = 2; c <= 5; c++) begin
            model_check();
            chk("cont_ret", 32'(mc_retire), (c == 3 || c == 4) ? 32'd1 : 32'd0);
            if (c == 3) chk("cont_addr3", 32'(mc_retire_addr), 32'd10);
            if (c == 4) chk("cont_addr4", 32'(mc_retire_addr), 32'd11);
            step();
        end

        // Exhaustion
        do_reset();
        mc_issue_EX = 1'b1; rf_waddr_EX = 5'd12; mc_lat_EX = 4'd15;
        model_check();
        step();
        rf_waddr_EX = 5'd13;
        model_check();
        step();
        idle();
        mc_req_ID = 1'b1;
        model_check();
        chk("exh_stall", 32'(stall_ID), 32'd1);
        mc_issue_EX = 1'b1; rf_waddr_EX = 5'd14; mc_lat_EX = 4'd1;
        model_check();
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            model_check();
            chk("exh_err", 32'(mc_err), 32'd1);
            step();
        end
        rst = 1'b1;
        model_check();
        step();
        rst = 1'b0;
        model_check();
        chk("exh_err_clr", 32'(mc_err), 32'd0);
        step();

        // Reset mid-op with cnt == 2
        mc_issue_EX = 1'b1; rf_waddr_EX = 5'd14; mc_lat_EX = 4'd5;
        model_check();
        step();
        idle();
        rf_raddr_ID = {5'd14, 5'd0}; rf_rused_ID = 2'b10;
        for (int c = 1; c <= 3; c++) begin
            model_check();
            step();
        end
        rst = 1'b1;
        model_check();
        chk("rmid_stall_pre", 32'(stall_ID), 32'd1);
        step();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            model_check();
            chk("rmid_stall", 32'(stall_ID), 32'd0);
            chk("rmid_ret", 32'(mc_retire), 32'd0);
            chk("rmid_err", 32'(mc_err), 32'd0);
            step();
        end

        // Randomized traffic against the reference
        for (int n = 0; n < 400; n++) begin
            rst          = ($urandom_range(0, 63) == 0);
            rf_raddr_ID  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rf_rused_ID  = 2'($urandom_range(0, 3));
            rf_wen_ID    = 1'($urandom_range(0, 1));
            rf_waddr_ID  = 5'($urandom_range(0, 7));
            mc_req_ID    = ($urandom_range(0, 3) == 0);
            rf_raddr_EX  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            rf_wen_EX    = 1'($urandom_range(0, 1));
            rf_waddr_EX  = 5'($urandom_range(0, 7));
            mem_read_EX  = 1'($urandom_range(0, 1));
            mc_issue_EX  = ($urandom_range(0, 3) == 0);
            mc_lat_EX    = 4'($urandom_range(0, 6));
            rf_wen_MEM   = 1'($urandom_range(0, 1));
            rf_waddr_MEM = 5'($urandom_range(0, 7));
            rf_wen_WB    = 1'($urandom_range(0, 1));
            rf_waddr_WB  = 5'($urandom_range(0, 7));
            model_check();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
